// File: rtl/w7_ram_loader_if.sv
// Byte-stream valid/ready channel feeding the layer-7 weight loader.
// The source drives valid/data and holds a byte until ready is seen.
interface w7_ram_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/w7_ram_loader.sv
// Packs a byte stream into 80-bit words for the layer-7 weight RAM
// and verifies the transfer against a trailing 8-bit checksum byte.
module w7_ram_loader #(
  parameter int DEPTH = 84
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  w7_ram_loader_if.slave         byte_if,
  output logic                   w7_we,
  output logic [6:0]             w7_waddr,
  output logic [79:0]            w7_wdata,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  byte_idx;
  logic [6:0]  addr;
  logic [7:0]  sum;
  logic [71:0] pack;
  logic        ready;
  logic        handshake;

  // Ready depends only on the registered state, never on byte_valid.
  assign ready             = (state == FILL) || (state == CHECK);
  assign byte_if.byte_ready = ready;
  assign handshake         = byte_if.byte_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    w7_we      = 1'b0;
    load_done  = 1'b0;
    load_busy  = 1'b1;
    case (state)
      IDLE: begin
        load_busy = 1'b0;
        if (load_start) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (handshake && (byte_idx == 4'd9)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        w7_we      = 1'b1;
        state_next = (addr == LAST_ADDR) ? CHECK : FILL;
      end
      CHECK: begin
        if (handshake) begin
          state_next = DONE;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The tenth byte goes straight into the output word, so w7_wdata stays
  // stable from its write cycle until the next word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= 4'd0;
      addr     <= 7'd0;
      sum      <= 8'd0;
      pack     <= 72'd0;
      w7_waddr <= 7'd0;
      w7_wdata <= 80'd0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            byte_idx <= 4'd0;
            addr     <= 7'd0;
            sum      <= 8'd0;
            load_err <= 1'b0;
          end
        end
        FILL: begin
          if (handshake) begin
            sum <= sum + byte_if.byte_data;
            if (byte_idx == 4'd9) begin
              w7_wdata <= {byte_if.byte_data, pack};
              w7_waddr <= addr;
            end else begin
              for (int k = 0; k < 9; k++) begin
                if (byte_idx == 4'(k)) begin
                  pack[8*k +: 8] <= byte_if.byte_data;
                end
              end
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        WRITE: begin
          byte_idx <= 4'd0;
          if (addr != LAST_ADDR) begin
            addr <= addr + 7'd1;
          end
        end
        CHECK: begin
          if (handshake) begin
            load_err <= (byte_if.byte_data != sum);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
